sipo_frame_ctrl: RTL and testbench

- Sequences a serial-in parallel-out shift register (SIPO) into framed words.
- Gates serial bit capture on a start pulse and counts DATA_WIDTH bits per word and NUM_WORDS words per frame.
- Hands each completed word to a downstream consumer over a one-entry valid/ready output buffer, and flags overflow.
- Sits between a serial link receiver and a word-oriented consumer.

---
 rtl/sipo_pkg.sv | 14 +
 rtl/sipo_shift_en.sv | 41 ++++
 rtl/sipo_frame_ctrl.sv | 133 +++++++++++++
 tb/tb_sipo_frame_ctrl.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/sipo_pkg.sv
// Shared types and width helpers for the framed SIPO controller.
package sipo_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    // Counter width for a count of n items; never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/sipo_shift_en.sv
// Serial-in shift stage with enable and synchronous clear.
// 'word' is the DATA_WIDTH-bit value formed by the stored bits plus the bit
// currently on din, so a completing bit can be handed off on the same edge.
// Only DATA_WIDTH-1 bits need storage: the newest bit always comes from din.
module sipo_shift_en #(
    parameter int DATA_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  en,
    input  logic                  clr,
    input  logic                  din,
    output logic [DATA_WIDTH-1:0] word
);

    logic [DATA_WIDTH-2:0] shift_reg;

    // Assemble the shifted-in word bit by bit: LSB from din, the rest from storage.
    genvar gi;
    generate
        for (gi = 0; gi < DATA_WIDTH; gi++) begin : g_word
            if (gi == 0) begin : g_lsb
                assign word[gi] = din;
            end else begin : g_upper
                assign word[gi] = shift_reg[gi-1];
            end
        end
    endgenerate

    // Clear has priority over a shift.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            shift_reg <= '0;
        end else if (clr) begin
            shift_reg <= '0;
        end else if (en) begin
            shift_reg <= word[DATA_WIDTH-2:0];
        end
    end

endmodule

// File: rtl/sipo_frame_ctrl.sv
// Frame sequencer for a serial-in parallel-out shifter: counts bits into
// words and words into frames, and hands each word to a one-entry
// valid/ready output buffer with a sticky overflow flag.
module sipo_frame_ctrl
    import sipo_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int NUM_WORDS  = 4
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  start,
    input  logic                  din_valid,
    input  logic                  din,
    output logic [DATA_WIDTH-1:0] dout,
    output logic                  dout_valid,
    input  logic                  dout_ready,
    output logic                  dout_last,
    output logic                  busy,
    output logic                  overflow
);

    localparam int BCW = cnt_width(DATA_WIDTH);
    localparam int WCW = cnt_width(NUM_WORDS);
    localparam logic [BCW-1:0] LAST_BIT  = BCW'(DATA_WIDTH - 1);
    localparam logic [WCW-1:0] LAST_WORD = WCW'(NUM_WORDS - 1);

    state_t                state_reg;
    logic [BCW-1:0]        bit_cnt_reg;
    logic [WCW-1:0]        word_cnt_reg;
    logic                  busy_reg;
    logic                  overflow_reg;
    logic [DATA_WIDTH-1:0] dout_reg;
    logic                  dout_valid_reg;
    logic                  dout_last_reg;

    logic                  bit_take;
    logic                  word_done;
    logic                  buf_free;
    logic                  shift_en;
    logic                  shift_clr;
    logic [DATA_WIDTH-1:0] word_next;

    // A start pulse always wins over a bit arriving in the same cycle.
    assign bit_take  = (state_reg == SHIFT) && din_valid && !start;
    assign word_done = bit_take && (bit_cnt_reg == LAST_BIT);
    assign buf_free  = !dout_valid_reg || dout_ready;
    assign shift_en  = bit_take && !word_done;
    assign shift_clr = start || word_done;

    sipo_shift_en #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_shift (
        .clk    (clk),
        .resetn (resetn),
        .en     (shift_en),
        .clr    (shift_clr),
        .din    (din),
        .word   (word_next)
    );

    // Frame FSM with bit/word counters, busy and sticky overflow.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_reg    <= IDLE;
            bit_cnt_reg  <= '0;
            word_cnt_reg <= '0;
            busy_reg     <= 1'b0;
            overflow_reg <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        state_reg    <= SHIFT;
                        bit_cnt_reg  <= '0;
                        word_cnt_reg <= '0;
                        overflow_reg <= 1'b0;
                        busy_reg     <= 1'b1;
                    end
                end
                SHIFT: begin
                    if (start) begin
                        bit_cnt_reg  <= '0;
                        word_cnt_reg <= '0;
                        overflow_reg <= 1'b0;
                    end else if (din_valid) begin
                        if (bit_cnt_reg == LAST_BIT) begin
                            bit_cnt_reg <= '0;
                            if (!buf_free) begin
                                overflow_reg <= 1'b1;
                            end
                            if (word_cnt_reg == LAST_WORD) begin
                                word_cnt_reg <= '0;
                                state_reg    <= IDLE;
                                busy_reg     <= 1'b0;
                            end else begin
                                word_cnt_reg <= word_cnt_reg + WCW'(1);
                            end
                        end else begin
                            bit_cnt_reg <= bit_cnt_reg + BCW'(1);
                        end
                    end
                end
                default: begin
                    state_reg <= IDLE;
                    busy_reg  <= 1'b0;
                end
            endcase
        end
    end

    // One-entry output buffer: fill on completion when free, else drain on accept.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            dout_reg       <= '0;
            dout_valid_reg <= 1'b0;
            dout_last_reg  <= 1'b0;
        end else if (word_done && buf_free) begin
            dout_reg       <= word_next;
            dout_valid_reg <= 1'b1;
            dout_last_reg  <= (word_cnt_reg == LAST_WORD);
        end else if (dout_valid_reg && dout_ready) begin
            dout_valid_reg <= 1'b0;
        end
    end

    assign dout       = dout_reg;
    assign dout_valid = dout_valid_reg;
    assign dout_last  = dout_last_reg;
    assign busy       = busy_reg;
    assign overflow   = overflow_reg;

endmodule

// File: tb/tb_sipo_frame_ctrl.sv
// Directed bench for sipo_frame_ctrl with DATA_WIDTH=8, NUM_WORDS=2.
module tb_sipo_frame_ctrl;

    localparam int DW = 8;
    localparam int NW = 2;

    logic          clk = 1'b0;
    logic          resetn = 1'b0;
    logic          start = 1'b0;
    logic          din_valid = 1'b0;
    logic          din = 1'b0;
    logic          dout_ready = 1'b0;
    logic [DW-1:0] dout;
    logic          dout_valid;
    logic          dout_last;
    logic          busy;
    logic          overflow;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    sipo_frame_ctrl #(
        .DATA_WIDTH(DW),
        .NUM_WORDS (NW)
    ) dut (
        .clk        (clk),
        .resetn     (resetn),
        .start      (start),
        .din_valid  (din_valid),
        .din        (din),
        .dout       (dout),
        .dout_valid (dout_valid),
        .dout_ready (dout_ready),
        .dout_last  (dout_last),
        .busy       (busy),
        .overflow   (overflow)
    );

    typedef struct {
        logic          st;
        logic          dv;
        logic          d;
        logic          rdy;
        logic [DW-1:0] e_dout;
        logic          e_v;
        logic          e_l;
        logic          e_b;
        logic          e_o;
        string         tag;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic add(input logic st, input logic dv, input logic d, input logic rdy,
                       input logic [DW-1:0] e_dout, input logic e_v, input logic e_l,
                       input logic e_b, input logic e_o, input string tag);
        vec_t v;
        v.st = st; v.dv = dv; v.d = d; v.rdy = rdy;
        v.e_dout = e_dout; v.e_v = e_v; v.e_l = e_l; v.e_b = e_b; v.e_o = e_o;
        v.tag = tag;
        vecs.push_back(v);
    endtask

    // Drive one cycle of inputs on the falling edge, then settle past the rising edge.
    task automatic step(input logic st, input logic dv, input logic d, input logic rdy);
        @(negedge clk);
        start = st; din_valid = dv; din = d; dout_ready = rdy;
        @(posedge clk);
        #1;
    endtask

    // Shift the n most significant bits of b, MSB first, contiguous.
    task automatic send_bits(input logic [DW-1:0] b, input int n, input logic rdy);
        for (int i = 0; i < n; i++) begin
            step(1'b0, 1'b1, b[DW-1-i], rdy);
        end
    endtask

    // Basic frame (contiguous or gapped) with dout_ready held high.
    // With the consumer always ready, dout_valid is high only right after a
    // completing bit; busy falls after the final bit of the frame.
    task automatic fill_frame(input bit gapped, input string tag);
        logic [DW-1:0] words [NW];
        logic [DW-1:0] w;
        logic          b;
        words[0] = 8'hA5;
        words[1] = 8'h3C;
        add(1'b1, 1'b0, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, {tag, " start"});
        for (int k = 0; k < NW; k++) begin
            w = words[k];
            for (int i = DW - 1; i >= 0; i--) begin
                b = w[i];
                if (gapped) begin
                    add(1'b0, 1'b0, ~b, 1'b1, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, {tag, " gap"});
                end
                add(1'b0, 1'b1, b, 1'b1, w, (i == 0), (i == 0) && (k == NW - 1),
                    !((i == 0) && (k == NW - 1)), 1'b0, {tag, " bit"});
            end
        end
        add(1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, {tag, " idle"});
    endtask

    initial begin
        // Reset state
        resetn = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset dout", dout, 8'h00);
        chk("reset dout_valid", dout_valid, 1'b0);
        chk("reset dout_last", dout_last, 1'b0);
        chk("reset busy", busy, 1'b0);
        chk("reset overflow", overflow, 1'b0);
        $display("txn reset: dout=%0h valid=%0b busy=%0b", dout, dout_valid, busy);
        @(negedge clk);
        resetn = 1'b1;

        // Table-driven basic and gapped frames
        fill_frame(1'b0, "basic");
        fill_frame(1'b1, "gapped");
        for (int k = 0; k < vecs.size(); k++) begin
            step(vecs[k].st, vecs[k].dv, vecs[k].d, vecs[k].rdy);
            chk({vecs[k].tag, " dout_valid"}, dout_valid, vecs[k].e_v);
            chk({vecs[k].tag, " busy"}, busy, vecs[k].e_b);
            chk({vecs[k].tag, " overflow"}, overflow, vecs[k].e_o);
            if (vecs[k].e_v) begin
                chk({vecs[k].tag, " dout"}, dout, vecs[k].e_dout);
                chk({vecs[k].tag, " dout_last"}, dout_last, vecs[k].e_l);
            end
            $display("vec %0d %s: st=%0b dv=%0b d=%0b rdy=%0b -> dout=%0h v=%0b l=%0b b=%0b o=%0b",
                     k, vecs[k].tag, vecs[k].st, vecs[k].dv, vecs[k].d, vecs[k].rdy,
                     dout, dout_valid, dout_last, busy, overflow);
        end

        // Backpressure: consumer never ready, second word dropped
        step(1'b1, 1'b0, 1'b0, 1'b0);
        chk("bp start busy", busy, 1'b1);
        send_bits(8'hA5, 8, 1'b0);
        chk("bp w1 valid", dout_valid, 1'b1);
        chk("bp w1 dout", dout, 8'hA5);
        chk("bp w1 last", dout_last, 1'b0);
        for (int i = 0; i < DW - 1; i++) begin
            step(1'b0, 1'b1, (8'h3C >> (DW - 1 - i)) & 1'b1, 1'b0);
            chk("bp hold dout", dout, 8'hA5);
            chk("bp hold valid", dout_valid, 1'b1);
        end
        step(1'b0, 1'b1, 1'b0, 1'b0);
        chk("bp drop dout", dout, 8'hA5);
        chk("bp drop valid", dout_valid, 1'b1);
        chk("bp drop last", dout_last, 1'b0);
        chk("bp drop overflow", overflow, 1'b1);
        chk("bp drop busy", busy, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        chk("bp drain valid", dout_valid, 1'b0);
        chk("bp sticky overflow", overflow, 1'b1);
        $display("txn backpressure: dout=%0h overflow=%0b", dout, overflow);

        // Simultaneous drain and fill on the completing bit of word 2
        step(1'b1, 1'b0, 1'b0, 1'b0);
        chk("sim start clears overflow", overflow, 1'b0);
        send_bits(8'hA5, 8, 1'b0);
        chk("sim w1 valid", dout_valid, 1'b1);
        send_bits(8'h3C, 7, 1'b0);
        chk("sim w1 held", dout, 8'hA5);
        step(1'b0, 1'b1, 1'b0, 1'b1);
        chk("sim w2 dout", dout, 8'h3C);
        chk("sim w2 valid", dout_valid, 1'b1);
        chk("sim w2 last", dout_last, 1'b1);
        chk("sim overflow", overflow, 1'b0);
        chk("sim busy", busy, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        chk("sim drain valid", dout_valid, 1'b0);
        $display("txn simultaneous: dout=%0h overflow=%0b", dout, overflow);

        // Restart after 5 bits, and start coincident with a completing bit
        step(1'b1, 1'b0, 1'b0, 1'b1);
        send_bits(8'hFF, 5, 1'b1);
        chk("rs partial valid", dout_valid, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b1);
        chk("rs restart busy", busy, 1'b1);
        send_bits(8'h81, 7, 1'b1);
        step(1'b1, 1'b1, 1'b1, 1'b1);
        chk("rs coincident valid", dout_valid, 1'b0);
        chk("rs coincident busy", busy, 1'b1);
        send_bits(8'h5A, 7, 1'b1);
        chk("rs w1 pre valid", dout_valid, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b1);
        chk("rs w1 dout", dout, 8'h5A);
        chk("rs w1 valid", dout_valid, 1'b1);
        chk("rs w1 last", dout_last, 1'b0);
        send_bits(8'hFF, 7, 1'b1);
        chk("rs w2 pre valid", dout_valid, 1'b0);
        step(1'b0, 1'b1, 1'b1, 1'b1);
        chk("rs w2 dout", dout, 8'hFF);
        chk("rs w2 valid", dout_valid, 1'b1);
        chk("rs w2 last", dout_last, 1'b1);
        chk("rs w2 busy", busy, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        chk("rs drain valid", dout_valid, 1'b0);
        $display("txn restart: dout=%0h busy=%0b", dout, busy);

        // Asynchronous reset between clock edges, mid-word
        step(1'b1, 1'b0, 1'b0, 1'b0);
        send_bits(8'hA5, 8, 1'b0);
        chk("ar pre valid", dout_valid, 1'b1);
        send_bits(8'h3C, 3, 1'b0);
        #3;
        resetn = 1'b0;
        #1;
        chk("ar dout", dout, 8'h00);
        chk("ar valid", dout_valid, 1'b0);
        chk("ar last", dout_last, 1'b0);
        chk("ar busy", busy, 1'b0);
        chk("ar overflow", overflow, 1'b0);
        @(negedge clk);
        resetn = 1'b1;
        send_bits(8'hA5, 8, 1'b1);
        chk("ar post valid", dout_valid, 1'b0);
        chk("ar post busy", busy, 1'b0);
        send_bits(8'h3C, 8, 1'b1);
        chk("ar post2 valid", dout_valid, 1'b0);
        $display("txn async reset: dout=%0h valid=%0b busy=%0b", dout, dout_valid, busy);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
